// File: rtl/score_pkg.sv
// score_pkg: shared sprite count, operand bit encoding, scheduler states and index wrap helper
package score_pkg;
  localparam int NUMBERS_DEF = 9;
  localparam int OP_PLUS = 0;
  localparam int OP_MINUS = 1;
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_HOLD, S_OFF} sched_state_t;
  function automatic logic [3:0] wrap_inc(input logic [3:0] i, input int n);
    return (int'(i) >= n - 1) ? 4'd0 : i + 4'd1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker returning the first set request at or after ptr
module rr_pick import score_pkg::*; #(
  parameter int N = NUMBERS_DEF
) (
  input  logic [N-1:0] req,
  input  logic [3:0]   ptr,
  output logic         found,
  output logic [3:0]   idx
);
  always_comb begin
    found = 1'b0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        found = 1'b1;
        idx = 4'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/hit_scheduler.sv
// hit_scheduler: serialises sprite and operand hit pulses into per-frame budgeted grants
module hit_scheduler import score_pkg::*; #(
  parameter int NUMBERS = NUMBERS_DEF,
  parameter int MAX_PER_FRAME = 4
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic [NUMBERS-1:0]      SingleHitPulse,
  input  logic [NUMBERS-1:0][3:0] NumbersToShow,
  input  logic [1:0]              operandHit,
  input  logic                    startOfFrame,
  input  logic                    enable,
  input  logic                    consumerReady,
  output logic                    GrantValid,
  output logic                    GrantIsOperand,
  output logic [3:0]              GrantIndex,
  output logic [3:0]              GrantValue,
  output logic [7:0]              DropCount
);
  localparam int FW = $clog2(MAX_PER_FRAME + 1);
  sched_state_t state, state_nxt;
  logic [NUMBERS-1:0] pending, clr_num;
  logic [NUMBERS-1:0][3:0] values;
  logic [1:0] op_pending, clr_op;
  logic [FW-1:0] frame_count;
  logic [3:0] rr_ptr, rr_idx;
  logic rr_found, live, accept, load, at_limit;
  logic [8:0] drop_sum;
  rr_pick #(.N(NUMBERS)) u_pick (.req(pending), .ptr(rr_ptr), .found(rr_found), .idx(rr_idx));
  always_comb begin
    GrantValid = state == S_GRANT;
    live = enable && state != S_OFF;
    accept = enable && state == S_GRANT && consumerReady;
    at_limit = frame_count == FW'(MAX_PER_FRAME) && !startOfFrame;
    load = enable && state == S_IDLE && !at_limit && (rr_found || |op_pending);
    state_nxt = !enable ? S_OFF :
                state == S_OFF ? S_IDLE :
                state == S_HOLD ? (startOfFrame ? S_IDLE : S_HOLD) :
                state == S_GRANT ? (consumerReady ? S_IDLE : S_GRANT) :
                at_limit ? S_HOLD : load ? S_GRANT : S_IDLE;
    clr_num = '0;
    clr_op = '0;
    drop_sum = {1'b0, DropCount};
    for (int i = 0; i < NUMBERS; i++) begin
      clr_num[i] = accept && !GrantIsOperand && GrantIndex == 4'(i);
      drop_sum = drop_sum + 9'(live && SingleHitPulse[i] && pending[i] && !clr_num[i]);
    end
    for (int k = 0; k < 2; k++) begin
      clr_op[k] = accept && GrantIsOperand && GrantIndex == 4'(k);
      drop_sum = drop_sum + 9'(live && operandHit[k] && op_pending[k] && !clr_op[k]);
    end
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= S_IDLE;
      pending <= '0;
      op_pending <= '0;
      frame_count <= '0;
      rr_ptr <= '0;
      DropCount <= '0;
      GrantIsOperand <= 1'b0;
      GrantIndex <= '0;
      GrantValue <= '0;
    end else begin
      state <= state_nxt;
      frame_count <= startOfFrame ? FW'(accept) : frame_count + FW'(accept);
      DropCount <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      for (int i = 0; i < NUMBERS; i++)
        pending[i] <= live && (SingleHitPulse[i] || (pending[i] && !clr_num[i]));
      for (int k = 0; k < 2; k++)
        op_pending[k] <= live && (operandHit[k] || (op_pending[k] && !clr_op[k]));
      if (accept && !GrantIsOperand)
        rr_ptr <= wrap_inc(GrantIndex, NUMBERS);
      if (load) begin
        GrantIsOperand <= |op_pending;
        GrantIndex <= op_pending[0] ? 4'(OP_PLUS) : op_pending[1] ? 4'(OP_MINUS) : rr_idx;
        GrantValue <= |op_pending ? 4'd0 : values[rr_idx];
      end
    end
  end
  always_ff @(posedge clk)
    for (int i = 0; i < NUMBERS; i++)
      if (live && SingleHitPulse[i] && (!pending[i] || clr_num[i]))
        values[i] <= NumbersToShow[i];
endmodule
